// File: rtl/hc_tx_port_arbiter_pkg.sv
// Shared arbiter definitions for the host-controller TX port.
// State codes and requester index constants.
package usbHostArb_h;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_GRANTED = 2'b01,
    ARB_RELEASE = 2'b10
  } arbState_t;

  localparam int ARB_REQ_SOF    = 0;
  localparam int ARB_REQ_PKT    = 1;
  localparam int ARB_REQ_DIRCTL = 2;

endpackage

// File: rtl/hc_tx_port_arbiter_prio_enc.sv
// Lowest-index-wins priority encoder.
// Returns the winning index and a valid flag.
module hc_tx_prio_enc #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hc_tx_port_arbiter.sv
// Fixed-priority, grant-locked arbiter for the SIE TX port.
// Optional grant timeout: define HC_TX_ARB_TIMEOUT_EN.
module hc_tx_port_arbiter
  import usbHostArb_h::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic [8*NUM_REQ-1:0] reqCntl,
  input  logic [8*NUM_REQ-1:0] reqData,
  input  logic [NUM_REQ-1:0]   reqWEn,
  output logic [NUM_REQ-1:0]   reqRdy,
  output logic [7:0]           HCTxPortCntl,
  output logic [7:0]           HCTxPortData,
  output logic                 HCTxPortWEn,
  input  logic                 HCTxPortRdy,
  output logic                 timeoutErr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arbState_t          state, stateNext;
  logic [IW-1:0]      owner, ownerNext, encIdx;
  logic               encValid, active;
  logic [NUM_REQ-1:0] gntNext, reqAvail;

`ifdef HC_TX_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0]      timer, timerNext;
  logic [NUM_REQ-1:0] blocked, blockSet;
  logic               errNext;

  assign reqAvail = req & ~blocked;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer      <= '0;
      blocked    <= '0;
      timeoutErr <= 1'b0;
    end else begin
      timer      <= timerNext;
      blocked    <= (blocked & req) | blockSet;
      timeoutErr <= errNext;
    end
  end
`else
  assign reqAvail   = req;
  assign timeoutErr = 1'b0;
`endif

  hc_tx_prio_enc #(.N(NUM_REQ), .IW(IW)) uEnc (
    .req   (reqAvail),
    .idx   (encIdx),
    .valid (encValid)
  );

  always_comb begin
    stateNext = state;
    ownerNext = owner;
    gntNext   = '0;
`ifdef HC_TX_ARB_TIMEOUT_EN
    timerNext = timer;
    blockSet  = '0;
    errNext   = 1'b0;
`endif
    unique case (state)
      ARB_IDLE: begin
        if (encValid) begin
          stateNext = ARB_GRANTED;
          ownerNext = encIdx;
          gntNext   = NUM_REQ'(1) << encIdx;
`ifdef HC_TX_ARB_TIMEOUT_EN
          timerNext = '0;
`endif
        end
      end
      ARB_GRANTED: begin
        gntNext = gnt;
        if (!req[owner]) begin
          stateNext = ARB_RELEASE;
          gntNext   = '0;
        end
`ifdef HC_TX_ARB_TIMEOUT_EN
        else if (timer == TMAX) begin
          stateNext = ARB_RELEASE;
          gntNext   = '0;
          errNext   = 1'b1;
          blockSet  = NUM_REQ'(1) << owner;
        end else begin
          timerNext = timer + 1'b1;
        end
`endif
      end
      ARB_RELEASE: stateNext = ARB_IDLE;
      default:     stateNext = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      owner <= '0;
      gnt   <= '0;
    end else begin
      state <= stateNext;
      owner <= ownerNext;
      gnt   <= gntNext;
    end
  end

  // Owner index is only trusted while GRANTED; everything else reads as idle.
  assign active       = (state == ARB_GRANTED);
  assign HCTxPortCntl = active ? reqCntl[8*int'(owner) +: 8] : 8'h00;
  assign HCTxPortData = active ? reqData[8*int'(owner) +: 8] : 8'h00;
  assign HCTxPortWEn  = active & reqWEn[owner];
  assign reqRdy       = gnt & {NUM_REQ{HCTxPortRdy}};

  always @(posedge clk) begin
    if (rst) begin
      assert ($onehot0(gnt));
      if (active) assert (int'(owner) < NUM_REQ);
    end
  end

endmodule
